// File: rtl/voice_capture_ctrl.sv
// -----------------------------------------------------------------------------
// voice_capture_ctrl
//
// Captures a fixed-length recording from a PDM microphone and hands it to a
// byte-wide RAM write port.  The controller generates the microphone clock,
// packs PDM bits MSB-first into bytes and issues one write per byte through a
// wr_en / wr_ready handshake.  In real mode (sample=0) the stored recording is
// followed by a comparator run; in sample mode (sample=1) the recording is only
// stored as the reference.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   reset       synchronous, active-high reset
//   record      one-cycle start pulse, honoured only in IDLE
//   sample      1 = store as reference sample, 0 = store then compare
//   mic_data    PDM bit from the microphone
//   mic_clk     generated microphone clock (low outside CAPTURE)
//   mic_lr_sel  channel select, tied to left (0)
//   wr_en       RAM write request, held until wr_ready
//   wr_addr     byte address of the pending write
//   wr_data     byte of the pending write
//   wr_sel      target buffer: 1 = sample RAM, 0 = real RAM
//   wr_ready    RAM accepts the pending write this cycle
//   cmp_start   one-cycle comparator start pulse
//   cmp_done    comparator finished
//   busy        controller not in IDLE
//   done        one-cycle end-of-operation pulse
//   overrun     sticky: a completed byte was dropped
// -----------------------------------------------------------------------------
module voice_capture_ctrl #(
   parameter int CLK_DIV = 50,
   parameter int WIDTH   = 8,
   parameter int NBYTES  = 1024,
   parameter int ADDR_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              record,
   input  logic              sample,
   input  logic              mic_data,
   output logic              mic_clk,
   output logic              mic_lr_sel,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              wr_sel,
   input  logic              wr_ready,
   output logic              cmp_start,
   input  logic              cmp_done,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = $clog2(NBYTES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   // mic_clk is registered, so it is raised one count early to be high
   // exactly while div_cnt_reg >= CLK_DIV/2.
   localparam logic [DIV_W-1:0] DIV_RISE   = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      DRAIN,
      COMPARE,
      FINISH
   } state_t;

   state_t             state_reg;
   logic [DIV_W-1:0]   div_cnt_reg;
   logic [BIT_W-1:0]   bit_cnt_reg;
   logic [CNT_W-1:0]   byte_cnt_reg;
   logic [WIDTH-1:0]   shift_reg;

   logic               strobe;
   logic               accept;
   logic [WIDTH-1:0]   byte_next;

   // The bit is taken at the end of the mic_clk high phase, when the
   // microphone output has had the whole half period to settle.
   assign strobe    = (state_reg == CAPTURE) && (div_cnt_reg == DIV_LAST);
   assign accept    = wr_en && wr_ready;
   assign byte_next = {shift_reg[WIDTH-2:0], mic_data};

   assign mic_lr_sel = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         bit_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         shift_reg    <= '0;
         mic_clk      <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_sel       <= 1'b0;
         cmp_start    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         // Retire an accepted write; a byte issued later in this block
         // overrides wr_en so back-to-back writes have no gap.
         if (accept) begin
            wr_en   <= 1'b0;
            wr_addr <= wr_addr + ADDR_W'(1);
         end

         case (state_reg)
            IDLE: begin
               if (record) begin
                  state_reg    <= CAPTURE;
                  busy         <= 1'b1;
                  wr_sel       <= sample;
                  wr_addr      <= '0;
                  div_cnt_reg  <= '0;
                  bit_cnt_reg  <= '0;
                  byte_cnt_reg <= '0;
                  shift_reg    <= '0;
                  mic_clk      <= 1'b0;
                  overrun      <= 1'b0;
               end
            end

            CAPTURE: begin
               if (div_cnt_reg == DIV_LAST) begin
                  div_cnt_reg <= '0;
                  mic_clk     <= 1'b0;
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                  mic_clk     <= (div_cnt_reg >= DIV_RISE);
               end

               if (strobe) begin
                  shift_reg <= byte_next;
                  if (bit_cnt_reg == BIT_LAST) begin
                     bit_cnt_reg  <= '0;
                     byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                     // A write still waiting for the RAM keeps its slot;
                     // the new byte is lost and the address stays put.
                     if (wr_en && !wr_ready) begin
                        overrun <= 1'b1;
                     end else begin
                        wr_en   <= 1'b1;
                        wr_data <= byte_next;
                     end
                     // Dropped bytes count toward the recording length so
                     // the recording always spans the same time window.
                     if (byte_cnt_reg == BYTE_LAST) begin
                        state_reg <= DRAIN;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                  end
               end
            end

            DRAIN: begin
               if (!wr_en || wr_ready) begin
                  if (wr_sel) begin
                     state_reg <= FINISH;
                     done      <= 1'b1;
                  end else begin
                     state_reg <= COMPARE;
                     cmp_start <= 1'b1;
                  end
               end
            end

            COMPARE: begin
               cmp_start <= 1'b0;
               if (cmp_done) begin
                  state_reg <= FINISH;
                  done      <= 1'b1;
               end
            end

            FINISH: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               cmp_start <= 1'b0;
               mic_clk   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_voice_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_voice_capture_ctrl
//
// Scoreboard bench for voice_capture_ctrl with CLK_DIV=4, WIDTH=8, NBYTES=4.
// Tests push the writes they expect into exp_q; a forked monitor pops and
// compares on every accepted write, checks held writes stay stable, counts
// cmp_start/done pulses and checks done follows cmp_done by one cycle.
// A microphone model drives the per-test byte pattern MSB-first on mic_clk.
// -----------------------------------------------------------------------------
module tb_voice_capture_ctrl;

   localparam int CLK_DIV = 4;
   localparam int WIDTH   = 8;
   localparam int NBYTES  = 4;
   localparam int ADDR_W  = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              record;
   logic              sample;
   logic              mic_data;
   logic              mic_clk;
   logic              mic_lr_sel;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_sel;
   logic              wr_ready;
   logic              cmp_start;
   logic              cmp_done;
   logic              busy;
   logic              done;
   logic              overrun;

   voice_capture_ctrl #(
      .CLK_DIV (CLK_DIV),
      .WIDTH   (WIDTH),
      .NBYTES  (NBYTES),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .record     (record),
      .sample     (sample),
      .mic_data   (mic_data),
      .mic_clk    (mic_clk),
      .mic_lr_sel (mic_lr_sel),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_sel     (wr_sel),
      .wr_ready   (wr_ready),
      .cmp_start  (cmp_start),
      .cmp_done   (cmp_done),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              sel;
   } wr_t;

   wr_t        exp_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         n_wr = 0;
   int         n_cmp_start = 0;
   int         n_done = 0;
   int         mic_viol = 0;
   logic [7:0] pat [0:3];
   logic       mic_clr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int a, input logic [7:0] d, input logic s);
      wr_t e;
      e.addr = ADDR_W'(a);
      e.data = d;
      e.sel  = s;
      exp_q.push_back(e);
   endtask

   // Watches the DUT every cycle; samples cmp_done at the rising edge and
   // everything else on the falling edge.
   task automatic monitor();
      logic              prev_pend = 1'b0;
      logic [ADDR_W-1:0] pa = '0;
      logic [7:0]        pd = '0;
      logic              prev_done = 1'b0;
      logic              cmp_seen;
      logic              in_compare = 1'b0;
      wr_t               e;
      forever begin
         @(posedge clk);
         cmp_seen = cmp_done;
         @(negedge clk);
         if (prev_pend) begin
            check("hold_wr_en", {31'd0, wr_en}, 32'd1);
            check("hold_wr_addr", 32'(wr_addr), 32'(pa));
            check("hold_wr_data", 32'(wr_data), 32'(pd));
         end
         if (!reset && wr_en && wr_ready) begin
            n_wr++;
            $display("write: addr=%0d data=0x%02h sel=%0b", wr_addr, wr_data, wr_sel);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_write: got addr=%0d data=0x%02h, expected none", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e.addr));
               check("wr_data", 32'(wr_data), 32'(e.data));
               check("wr_sel", {31'd0, wr_sel}, {31'd0, e.sel});
            end
         end
         prev_pend = !reset && wr_en && !wr_ready;
         pa = wr_addr;
         pd = wr_data;
         if (cmp_start) begin
            n_cmp_start++;
            in_compare = 1'b1;
            $display("cmp_start pulse");
         end
         if (cmp_seen) check("done_after_cmp_done", {31'd0, done}, 32'd1);
         if (done) begin
            n_done++;
            in_compare = 1'b0;
            check("done_one_cycle", {31'd0, prev_done}, 32'd0);
            $display("done pulse: overrun=%0b wr_sel=%0b", overrun, wr_sel);
         end
         prev_done = done;
         if (mic_clk && (!busy || in_compare)) mic_viol++;
      end
   endtask

   // Comparator model: finishes 5 cycles after its start pulse.
   task automatic responder();
      cmp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (cmp_start) begin
            repeat (5) @(negedge clk);
            cmp_done = 1'b1;
            @(negedge clk);
            cmp_done = 1'b0;
         end
      end
   endtask

   // Microphone model: presents the next pattern bit on each mic_clk rise.
   task automatic mic_drv();
      int         idx = 0;
      logic [7:0] b;
      mic_data = 1'b0;
      forever begin
         @(posedge mic_clk or posedge mic_clr);
         if (mic_clr) begin
            idx = 0;
         end else begin
            b = pat[idx / 8];
            mic_data = b[7 - (idx % 8)];
            idx = (idx + 1) % 32;
         end
      end
   endtask

   // Raises record for one cycle; returns #1 after the edge that samples it.
   task automatic start_record(input logic s);
      @(posedge clk);
      #1;
      sample  = s;
      record  = 1'b1;
      mic_clr = 1'b1;
      #1 mic_clr = 1'b0;
      @(posedge clk);
      #1 record = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      int  d0 = n_done;
      bit  ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         #1;
         if (n_done > d0) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_seen", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      check("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic end_checks(input int w0, input int c0, input int exp_w,
                             input int exp_c, input logic exp_sel, input logic exp_ovr);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("write_count", 32'(n_wr - w0), 32'(exp_w));
      check("cmp_start_count", 32'(n_cmp_start - c0), 32'(exp_c));
      check("wr_sel_final", {31'd0, wr_sel}, {31'd0, exp_sel});
      check("overrun_final", {31'd0, overrun}, {31'd0, exp_ovr});
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mic_clk"},    {31'd0, mic_clk},    32'd0);
      check({tag, "_mic_lr_sel"}, {31'd0, mic_lr_sel}, 32'd0);
      check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
      check({tag, "_wr_addr"},    32'(wr_addr),        32'd0);
      check({tag, "_wr_data"},    32'(wr_data),        32'd0);
      check({tag, "_wr_sel"},     {31'd0, wr_sel},     32'd0);
      check({tag, "_cmp_start"},  {31'd0, cmp_start},  32'd0);
      check({tag, "_busy"},       {31'd0, busy},       32'd0);
      check({tag, "_done"},       {31'd0, done},       32'd0);
      check({tag, "_overrun"},    {31'd0, overrun},    32'd0);
   endtask

   initial begin
      int         w0;
      int         c0;
      int         lat;
      bit         found;
      logic [7:0] mic_bits;
      int         stray;

      reset    = 1'b1;
      record   = 1'b0;
      sample   = 1'b0;
      wr_ready = 1'b1;
      pat[0] = 8'h00; pat[1] = 8'h00; pat[2] = 8'h00; pat[3] = 8'h00;

      fork
         monitor();
         responder();
         mic_drv();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // ---- 1: sample mode, 0xA5 every byte, latency and mic_clk shape ----
      $display("test 1: sample mode, pattern 0xA5");
      pat[0] = 8'hA5; pat[1] = 8'hA5; pat[2] = 8'hA5; pat[3] = 8'hA5;
      for (int i = 0; i < 4; i++) push(i, 8'hA5, 1'b1);
      w0 = n_wr; c0 = n_cmp_start;
      @(posedge clk);
      #1;
      sample = 1'b1; record = 1'b1; mic_clr = 1'b1;
      #1 mic_clr = 1'b0;
      lat = 0; found = 1'b0; mic_bits = '0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         record = 1'b0;
         if (k <= 8) mic_bits = {mic_bits[6:0], mic_clk};
         if (wr_en) begin
            lat = k;
            found = 1'b1;
            break;
         end
      end
      check("first_wr_seen", {31'd0, found}, 32'd1);
      check("first_wr_latency", 32'(lat), 32'd33);
      check("mic_clk_pattern", {24'd0, mic_bits}, 32'h33);
      wait_done(400);
      end_checks(w0, c0, 4, 0, 1'b1, 1'b0);

      // ---- 2: real mode with comparator handshake ----
      $display("test 2: real mode, compare");
      pat[0] = 8'h3C; pat[1] = 8'hF0; pat[2] = 8'h96; pat[3] = 8'h5A;
      push(0, 8'h3C, 1'b0); push(1, 8'hF0, 1'b0); push(2, 8'h96, 1'b0); push(3, 8'h5A, 1'b0);
      w0 = n_wr; c0 = n_cmp_start;
      start_record(1'b0);
      wait_done(400);
      end_checks(w0, c0, 4, 1, 1'b0, 1'b0);

      // ---- 3: RAM stalls on byte 1, byte 2 is dropped ----
      $display("test 3: wr_ready stall, overrun");
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1); push(2, 8'h44, 1'b1);
      w0 = n_wr; c0 = n_cmp_start;
      start_record(1'b1);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (wr_en && wr_addr == ADDR_W'(1)) begin
            found = 1'b1;
            break;
         end
      end
      check("byte1_issued", {31'd0, found}, 32'd1);
      wr_ready = 1'b0;
      repeat (40) @(posedge clk);
      #1 wr_ready = 1'b1;
      wait_done(400);
      end_checks(w0, c0, 3, 0, 1'b1, 1'b1);

      // ---- 4: record pulses during CAPTURE are ignored ----
      $display("test 4: record during capture");
      pat[0] = 8'hC3; pat[1] = 8'h81; pat[2] = 8'h7E; pat[3] = 8'h0F;
      for (int i = 0; i < 4; i++) push(i, pat[i], 1'b1);
      w0 = n_wr; c0 = n_cmp_start;
      start_record(1'b1);
      repeat (50) @(posedge clk);
      #1 record = 1'b1;
      @(posedge clk);
      #1 record = 1'b0;
      repeat (40) @(posedge clk);
      #1 record = 1'b1;
      @(posedge clk);
      #1 record = 1'b0;
      wait_done(400);
      end_checks(w0, c0, 4, 0, 1'b1, 1'b0);

      // ---- 5: reset with a write pending, then a fresh recording ----
      $display("test 5: reset mid-write");
      pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56; pat[3] = 8'h78;
      push(0, 8'h12, 1'b1); push(1, 8'h34, 1'b1);
      w0 = n_wr;
      start_record(1'b1);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (n_wr - w0 == 2) begin
            found = 1'b1;
            break;
         end
      end
      check("two_writes_before_reset", {31'd0, found}, 32'd1);
      wr_ready = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (wr_en) begin
            found = 1'b1;
            break;
         end
      end
      check("byte2_pending", {31'd0, found}, 32'd1);
      check("byte2_addr", 32'(wr_addr), 32'd2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("midreset");
      reset = 1'b0;
      wr_ready = 1'b1;
      stray = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (wr_en || busy) stray++;
      end
      check("no_wr_after_reset", 32'(stray), 32'd0);
      check("queue_empty_after_reset", 32'(exp_q.size()), 32'd0);

      pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'hFF; pat[3] = 8'h00;
      for (int i = 0; i < 4; i++) push(i, pat[i], 1'b1);
      w0 = n_wr; c0 = n_cmp_start;
      start_record(1'b1);
      wait_done(400);
      end_checks(w0, c0, 4, 0, 1'b1, 1'b0);

      check("mic_clk_idle_violations", 32'(mic_viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at %0t, expected $finish", $time);
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/voice_capture_ctrl.md
VOICE_CAPTURE_CTRL -- requirements
Module: voice_capture_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50, clk cycles per mic_clk period; SHALL be even and at least 4.
REQ-002 Parameter WIDTH, default 8, bits per stored sample byte.
REQ-003 Parameter NBYTES, default 1024, bytes captured per recording.
REQ-004 Parameter ADDR_W, default 10, write-address width; SHALL satisfy 2^ADDR_W >= NBYTES.
REQ-005 clk  in  1  single system clock (100 MHz); all logic SHALL be on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 record  in  1  debounced one-cycle start pulse.
REQ-008 sample  in  1  mode: 1 = store as reference sample, 0 = real mode (store then compare).
REQ-009 mic_data  in  1  PDM bit from microphone.
REQ-010 mic_clk  out  1  generated microphone clock.
REQ-011 mic_lr_sel  out  1  channel select; SHALL be constant 0 (left).
REQ-012 wr_en  out  1  RAM write request.
REQ-013 wr_addr  out  ADDR_W  byte address of the pending write.
REQ-014 wr_data  out  WIDTH  byte of the pending write.
REQ-015 wr_sel  out  1  target buffer: 1 = sample RAM, 0 = real RAM.
REQ-016 wr_ready  in  1  RAM accepts the write this cycle.
REQ-017 cmp_start  out  1  one-cycle comparator start pulse.
REQ-018 cmp_done  in  1  comparator finished.
REQ-019 busy  out  1  controller not in IDLE.
REQ-020 done  out  1  one-cycle end-of-operation pulse.
REQ-021 overrun  out  1  sticky flag: a byte was lost.

Function
REQ-022 FSM states: IDLE, CAPTURE, DRAIN, COMPARE, FINISH.
REQ-023 IDLE: on record=1, go to CAPTURE next cycle; latch sample into wr_sel; clear the address, bit counter, divider and overrun.
REQ-024 record SHALL be ignored in every state except IDLE.
REQ-025 Divider div_cnt counts 0..CLK_DIV-1 only in CAPTURE and is 0 on the first CAPTURE cycle.
REQ-026 mic_clk SHALL be 1 when div_cnt >= CLK_DIV/2 in CAPTURE, and 0 in all other states.
REQ-027 Sample strobe: on the cycle div_cnt == CLK_DIV-1, shift mic_data in at the LSB (MSB-first byte order).
REQ-028 On the WIDTH-th strobe the byte is complete; next cycle, wr_en=1 with wr_data = that byte and wr_addr = current address.
REQ-029 Handshake: wr_en, wr_addr and wr_data SHALL be held stable until a cycle with wr_ready=1; wr_en drops the cycle after acceptance unless a new byte is issued.
REQ-030 The address increments by 1 per accepted write and never wraps within a recording.
REQ-031 If a byte completes while a previous write is still unaccepted, the new byte SHALL be dropped, overrun set, and the address not advanced.
REQ-032 The bit counter wraps WIDTH-1 -> 0 with no gap; capture of the next byte continues during a pending write.
REQ-033 After NBYTES bytes complete (including dropped bytes), leave CAPTURE for DRAIN; mic_clk stops.
REQ-034 DRAIN: wait until no write is pending; then go to COMPARE if wr_sel=0, else to FINISH.
REQ-035 COMPARE: cmp_start=1 on the first COMPARE cycle only; wait for cmp_done=1, then go to FINISH.
REQ-036 cmp_done=1 on the same cycle as cmp_start is accepted.
REQ-037 FINISH: done=1 for exactly one cycle, then go to IDLE.
REQ-038 busy SHALL be 1 in every state except IDLE.
REQ-039 overrun holds its value until the next accepted record pulse.

Reset
REQ-040 reset=1 SHALL force IDLE from any state, including mid-capture and mid-write, on the next edge.
REQ-041 Reset values: mic_clk=0, mic_lr_sel=0, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, cmp_start=0, busy=0, done=0, overrun=0; divider, bit counter and shift register 0.
REQ-042 After reset, a pending write SHALL be abandoned with no further wr_en.

Verification (CLK_DIV=4, WIDTH=8, NBYTES=4)
REQ-043 record at cycle t, sample=1, wr_ready=1, mic_data pattern 0xA5 per byte -> first wr_en at t+33 with wr_addr=0 and wr_data=0xA5; addresses 0..3; done pulse; cmp_start never asserted; wr_sel=1.
REQ-044 sample=0, cmp_done asserted 5 cycles after cmp_start -> exactly one cmp_start pulse, done one cycle after cmp_done, then busy=0.
REQ-045 wr_ready=0 for 40 cycles at byte 1 -> write held stable, byte 2 dropped, overrun=1, final write count 3, done still asserted.
REQ-046 record pulsed during CAPTURE -> no restart, address sequence unchanged.
REQ-047 reset asserted mid-byte 2 with wr_en high -> next cycle all outputs at reset values; a fresh record then starts at wr_addr=0.
REQ-048 mic_clk period check -> 2 cycles low, 2 cycles high in CAPTURE; constant 0 in IDLE, DRAIN and COMPARE.
